dbg_access_port: RTL and testbench
==================================

# dbg_access_port

Host-side debug responder on the NPC core. The simulation harness or a debug transport issues commands over a valid/ready request channel: halt, resume, single-step, and read/write of a GPR or the PC. The block halts the core through a halt/ack handshake, performs the register-file or PC access while the core is halted, and returns one response per request. It sits between the harness-facing debug channel and the core's register file and PC update logic.

## Interface
- XLEN, 64, data width of GPRs and PC
- NREG, 32, number of GPRs; address width is log2(NREG)
- HALT_TIMEOUT, 256, cycles to wait for core_halted before failing a HALT
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready; high only in IDLE
- req_op  in  3  opcode: 0 STATUS, 1 HALT, 2 RESUME, 3 STEP, 4 RD_GPR, 5 WR_GPR, 6 RD_PC, 7 WR_PC
- req_addr  in  5  GPR index
- req_wdata  in  XLEN  write data
- rsp_valid  out  1  response valid; held until rsp_ready
- rsp_ready  in  1  response accepted
- rsp_data  out  XLEN  read data or status word
- rsp_err  out  1  command refused or timed out
- halt_req  out  1  level; core stalls and drains while high
- core_halted  in  1  core is drained and stalled
- step_req  out  1  one-cycle pulse: retire one instruction
- step_done  in  1  the stepped instruction has retired
- rf_raddr  out  5  GPR read address; the read is combinational
- rf_rdata  in  XLEN  GPR read data
- rf_wen, rf_waddr, rf_wdata  out  1/5/XLEN  GPR write port
- pc  in  XLEN  current PC
- pc_wen, pc_wdata  out  1/XLEN  PC overwrite
- is_break  in  1  ebreak retiring

## Operation
- FSM states: IDLE, HALTING, STEPPING, ACCESS, RESP. A request is accepted when req_valid && req_ready. The block latches op, addr and wdata on acceptance.
- STATUS:
  - Goes to RESP.
  - rsp_data = {zeros, break_seen[1], halted[0]}, where halted = halt_req && core_halted.
- HALT:
  - Sets halt_req and enters HALTING.
  - When core_halted is seen, goes to RESP with rsp_err=0.
  - If HALT_TIMEOUT cycles pass first, clears halt_req and responds with rsp_err=1.
  - If the core is already halted, goes straight to RESP.
- RESUME: clears halt_req and break_seen, then goes to RESP. It never errors.
- STEP:
  - Requires halted; otherwise RESP with err=1.
  - Pulses step_req, enters STEPPING and waits for step_done, then goes to RESP. There is no timeout.
- RD_GPR, WR_GPR, RD_PC, WR_PC:
  - Require halted; otherwise RESP with err=1, rsp_data=0, and no write is issued.
  - Otherwise the block enters ACCESS for one cycle and performs the read sample or issues a one-cycle write pulse.
- WR_GPR to x0: the write is suppressed (rf_wen stays 0) and the response is err=0.
- Any rsp_err response drives rsp_data=0.

## Timing
- Reset:
  - State goes to IDLE.
  - halt_req, step_req, rf_wen, pc_wen, rsp_valid and rsp_err go to 0.
  - rsp_data and the write buses go to 0.
  - break_seen goes to 0. req_ready is 1.
- Register access, request accepted at cycle N:
  - ACCESS at N+1: rf_raddr or rf_wen/pc_wen valid; read data registered.
  - rsp_valid at N+2.
- HALT and STEP latency is 1 cycle plus the core acknowledge, then rsp_valid the next cycle.
- Responses follow valid/ready: rsp_data and rsp_err are stable while rsp_valid && !rsp_ready. The block returns to IDLE in the cycle after the handshake. Requests never overlap.
- Asserting rst_n low mid-command aborts immediately:
  - halt_req drops, any pending response is lost, and no write is issued after reset.
  - A write pulse that was already issued is not reverted.

## Configuration
- DBG_BREAK_HALT_EN defined:
  - A cycle with is_break=1 and halt_req=0 sets halt_req and the sticky break_seen.
  - If this occurs in IDLE, no response is generated. The host discovers the halt by polling STATUS.
  - If it coincides with a HALT acceptance, the HALT proceeds normally and break_seen is still set.
- DBG_BREAK_HALT_EN undefined: is_break is ignored and break_seen always reads 0.

## Structure
- Package dbg_pkg holds:
  - the opcode enum and FSM state enum
  - the STATUS bit positions (HALTED=0, BREAK=1)
  - the default HALT_TIMEOUT
- Sub-module dbg_halt_timer is a loadable down-counter with a timeout flag. It is cleared on entry to HALTING and on reset.

## Test plan
- After reset, STATUS → rsp_data=0, err=0. Then RD_GPR x5 while running → err=1, data=0, no rf access.
- HALT with core_halted raised 3 cycles after halt_req → rsp_valid one cycle after the ack, err=0. STATUS → 0x1.
- While halted, WR_GPR x5=0xDEADBEEF, then RD_GPR x5 → 0xDEADBEEF. The write is a single-cycle rf_wen. RD_GPR follows the N+2 latency.
- WR_GPR x0=0x1 → rf_wen never rises, err=0.
- HALT with core_halted held low → err=1 after exactly 256 cycles, and halt_req is 0 afterwards.
- With DBG_BREAK_HALT_EN defined, pulse is_break → halt_req=1 and STATUS → 0x3 once the core acks. RESUME → halt_req=0, STATUS → 0x0. Assert rst_n low during STEPPING → all outputs return to their reset values.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug access port: opcodes, FSM states,
// STATUS word bit positions and the default HALT timeout.
package dbg_pkg;

    typedef enum logic [2:0] {
        OP_STATUS = 3'd0,
        OP_HALT   = 3'd1,
        OP_RESUME = 3'd2,
        OP_STEP   = 3'd3,
        OP_RD_GPR = 3'd4,
        OP_WR_GPR = 3'd5,
        OP_RD_PC  = 3'd6,
        OP_WR_PC  = 3'd7
    } dbg_op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HALTING  = 3'd1,
        S_STEPPING = 3'd2,
        S_ACCESS   = 3'd3,
        S_RESP     = 3'd4
    } dbg_state_e;

    localparam int STATUS_HALTED        = 0;
    localparam int STATUS_BREAK         = 1;
    localparam int HALT_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/dbg_access_port_halt_timer.sv
// Loadable down-counter bounding the HALT handshake; timeout is high once the
// count reaches zero, i.e. in the TIMEOUT-th enabled cycle after a load.
module dbg_halt_timer
    import dbg_pkg::*;
#(
    parameter int TIMEOUT = HALT_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign timeout = (count == '0);

endmodule

// File: rtl/dbg_access_port.sv
// Debug responder: halts the core, accesses GPRs/PC while halted, one response
// per request. Optional DBG_BREAK_HALT_EN lets a retiring ebreak halt the core.
//
// state      | meaning
// IDLE       | ready for a request
// HALTING    | halt_req high, waiting for core_halted or timeout
// STEPPING   | step issued, waiting for step_done
// ACCESS     | one-cycle GPR/PC read sample or write pulse
// RESP       | response valid, waiting for rsp_ready
module dbg_access_port
    import dbg_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int NREG         = 32,
    parameter int HALT_TIMEOUT = HALT_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [$clog2(NREG)-1:0]   req_addr,
    input  logic [XLEN-1:0]           req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [XLEN-1:0]           rsp_data,
    output logic                      rsp_err,
    output logic                      halt_req,
    input  logic                      core_halted,
    output logic                      step_req,
    input  logic                      step_done,
    output logic [$clog2(NREG)-1:0]   rf_raddr,
    input  logic [XLEN-1:0]           rf_rdata,
    output logic                      rf_wen,
    output logic [$clog2(NREG)-1:0]   rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    input  logic [XLEN-1:0]           pc,
    output logic                      pc_wen,
    output logic [XLEN-1:0]           pc_wdata,
    input  logic                      is_break
);

    localparam int AW = $clog2(NREG);

    dbg_state_e     state, state_nxt;
    dbg_op_e        op_q, op_nxt;
    logic [AW-1:0]  addr_q, addr_nxt;
    logic [XLEN-1:0] wdata_q, wdata_nxt;
    logic           halt_req_nxt, step_req_nxt;
    logic           break_seen, break_nxt;
    logic [XLEN-1:0] rsp_data_nxt;
    logic           rsp_err_nxt;
    logic           timer_load, timeout;
    logic           halted;
    logic [XLEN-1:0] status_word;

    dbg_halt_timer #(.TIMEOUT(HALT_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (state == S_HALTING),
        .timeout (timeout)
    );

    assign halted = halt_req && core_halted;

    always_comb begin
        status_word                = '0;
        status_word[STATUS_HALTED] = halted;
        status_word[STATUS_BREAK]  = break_seen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= OP_STATUS;
            addr_q     <= '0;
            wdata_q    <= '0;
            halt_req   <= 1'b0;
            step_req   <= 1'b0;
            break_seen <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            op_q       <= op_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            halt_req   <= halt_req_nxt;
            step_req   <= step_req_nxt;
            break_seen <= break_nxt;
            rsp_data   <= rsp_data_nxt;
            rsp_err    <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        op_nxt       = op_q;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        halt_req_nxt = halt_req;
        step_req_nxt = 1'b0;
        break_nxt    = break_seen;
        rsp_data_nxt = rsp_data;
        rsp_err_nxt  = rsp_err;
        timer_load   = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    op_nxt       = dbg_op_e'(req_op);
                    addr_nxt     = req_addr;
                    wdata_nxt    = req_wdata;
                    rsp_data_nxt = '0;
                    rsp_err_nxt  = 1'b0;
                    state_nxt    = S_RESP;
                    case (dbg_op_e'(req_op))
                        OP_STATUS: rsp_data_nxt = status_word;
                        OP_HALT: begin
                            if (!halted) begin
                                halt_req_nxt = 1'b1;
                                timer_load   = 1'b1;
                                state_nxt    = S_HALTING;
                            end
                        end
                        OP_RESUME: begin
                            halt_req_nxt = 1'b0;
                            break_nxt    = 1'b0;
                        end
                        OP_STEP: begin
                            if (halted) begin
                                step_req_nxt = 1'b1;
                                state_nxt    = S_STEPPING;
                            end else begin
                                rsp_err_nxt = 1'b1;
                            end
                        end
                        default: begin
                            if (halted) state_nxt = S_ACCESS;
                            else        rsp_err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            S_HALTING: begin
                if (core_halted) begin
                    state_nxt = S_RESP;
                end else if (timeout) begin
                    halt_req_nxt = 1'b0;
                    rsp_err_nxt  = 1'b1;
                    state_nxt    = S_RESP;
                end
            end
            S_STEPPING: begin
                if (step_done) state_nxt = S_RESP;
            end
            S_ACCESS: begin
                if (op_q == OP_RD_GPR)     rsp_data_nxt = rf_rdata;
                else if (op_q == OP_RD_PC) rsp_data_nxt = pc;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

`ifdef DBG_BREAK_HALT_EN
        // Applied last so a break still wins when it lands on a HALT acceptance.
        if (is_break && !halt_req) begin
            halt_req_nxt = 1'b1;
            break_nxt    = 1'b1;
        end
`endif
    end

`ifndef DBG_BREAK_HALT_EN
    logic break_unused;
    assign break_unused = is_break;
`endif

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    // Write ports are gated by ACCESS so they idle at zero everywhere else.
    assign rf_wen   = (state == S_ACCESS) && (op_q == OP_WR_GPR) && (addr_q != '0);
    assign rf_waddr = rf_wen ? addr_q : '0;
    assign rf_wdata = rf_wen ? wdata_q : '0;
    assign pc_wen   = (state == S_ACCESS) && (op_q == OP_WR_PC);
    assign pc_wdata = pc_wen ? wdata_q : '0;
    assign rf_raddr = ((state == S_ACCESS) && (op_q == OP_RD_GPR)) ? addr_q : '0;

endmodule

// File: tb/tb_dbg_access_port.sv
// Bench for dbg_access_port: a small core model answers halt/step and holds the
// register file; expectations come from an architectural model of the commands.
module tb_dbg_access_port;

    localparam int XLEN = 64;
    localparam int HTO  = 256;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = '0;
    logic [4:0]      req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;
    logic            halt_req;
    logic            core_halted;
    logic            step_req;
    logic            step_done;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [XLEN-1:0] pc;
    logic            pc_wen;
    logic [XLEN-1:0] pc_wdata;
    logic            is_break = 1'b0;

    always #5 clk = ~clk;

    dbg_access_port dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .halt_req(halt_req), .core_halted(core_halted),
        .step_req(step_req), .step_done(step_done),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .pc_wen(pc_wen), .pc_wdata(pc_wdata),
        .is_break(is_break)
    );

    // Core model
    logic [XLEN-1:0] core_rf [32];
    logic [XLEN-1:0] core_pc;
    logic [XLEN-1:0] init_rf [32];
    logic [XLEN-1:0] init_pc;
    bit core_init = 1'b1;
    bit never_ack = 1'b0;
    int ack_delay = 2;
    int step_delay = 1;
    int hcnt = 0;
    int scnt = 0;
    int n_rf_wen = 0, n_pc_wen = 0, n_step = 0;

    assign rf_rdata = core_rf[rf_raddr];
    assign pc = core_pc;

    always @(posedge clk) begin
        if (!halt_req) begin
            hcnt <= 0;
            core_halted <= 1'b0;
        end else begin
            hcnt <= hcnt + 1;
            if (!never_ack && (hcnt + 1 >= ack_delay)) core_halted <= 1'b1;
        end
        if (step_req) scnt <= step_delay;
        else if (scnt > 0) scnt <= scnt - 1;
        step_done <= (!step_req && scnt == 1);
        if (core_init) begin
            core_rf <= init_rf;
            core_pc <= init_pc;
        end else begin
            if (rf_wen) core_rf[rf_waddr] <= rf_wdata;
            if (pc_wen) core_pc <= pc_wdata;
            else if (!step_req && scnt == 1) core_pc <= core_pc + 64'd4;
        end
    end

    always @(posedge clk) begin
        if (rf_wen)   n_rf_wen <= n_rf_wen + 1;
        if (pc_wen)   n_pc_wen <= n_pc_wen + 1;
        if (step_req) n_step   <= n_step + 1;
    end

    // Architectural expectation model
    logic [XLEN-1:0] exp_rf [32];
    logic [XLEN-1:0] exp_pc;
    bit exp_halted = 1'b0;
    bit exp_break  = 1'b0;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_ctl"}, {58'd0, rsp_valid, rsp_err, halt_req, step_req, rf_wen, pc_wen}, 64'd0);
        chk({tag, "_rsp_data"}, rsp_data, 64'd0);
        chk({tag, "_rf_wdata"}, rf_wdata, 64'd0);
        chk({tag, "_rf_waddr"}, {59'd0, rf_waddr}, 64'd0);
        chk({tag, "_pc_wdata"}, pc_wdata, 64'd0);
    endtask

    task automatic do_cmd(input int op, input logic [4:0] addr, input logic [63:0] wd,
                          input int stall, output logic [63:0] d, output logic e, output int lat);
        int n = 0;
        d = '0;
        e = 1'b0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid_wait", {63'd0, rsp_valid}, 64'd1);
        d = rsp_data;
        e = rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_data", rsp_data, d);
            chk("hold_err", {63'd0, rsp_err}, {63'd0, e});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_after_hs", {62'd0, req_ready, rsp_valid}, 64'd2);
    endtask

    // Issue one command and check it against the model.
    task automatic exec(input int op, input logic [4:0] addr, input logic [63:0] wd);
        logic [63:0] d, xd;
        logic e, xe;
        int lat, xlat, xrf, xpc, xst, rf0, pc0, st0;
        bit cd;
        rf0 = n_rf_wen; pc0 = n_pc_wen; st0 = n_step;
        xd = '0; xe = 1'b0; xlat = 1; xrf = 0; xpc = 0; xst = 0; cd = 1'b1;
        case (op)
            0: xd = {62'd0, exp_break, exp_halted};
            1: begin
                cd = 1'b0;
                if (!exp_halted) begin
                    if (never_ack) begin
                        xlat = 1 + HTO;
                        xe   = 1'b1;
                        cd   = 1'b1;
                    end else begin
                        xlat = 1 + ack_delay + 1;
                        exp_halted = 1'b1;
                    end
                end
            end
            2: begin
                cd = 1'b0;
                exp_halted = 1'b0;
                exp_break  = 1'b0;
            end
            3: begin
                if (!exp_halted) xe = 1'b1;
                else begin
                    cd = 1'b0;
                    xlat = 1 + (step_delay + 1) + 1;
                    xst = 1;
                    exp_pc = exp_pc + 64'd4;
                end
            end
            4: begin
                if (!exp_halted) xe = 1'b1;
                else begin xd = exp_rf[addr]; xlat = 2; end
            end
            5: begin
                if (!exp_halted) xe = 1'b1;
                else begin
                    cd = 1'b0;
                    xlat = 2;
                    if (addr != 5'd0) begin exp_rf[addr] = wd; xrf = 1; end
                end
            end
            6: begin
                if (!exp_halted) xe = 1'b1;
                else begin xd = exp_pc; xlat = 2; end
            end
            default: begin
                if (!exp_halted) xe = 1'b1;
                else begin cd = 1'b0; xlat = 2; exp_pc = wd; xpc = 1; end
            end
        endcase
        do_cmd(op, addr, wd, $urandom_range(0, 3), d, e, lat);
        chk($sformatf("op%0d_err", op), {63'd0, e}, {63'd0, xe});
        if (cd) chk($sformatf("op%0d_data", op), d, xd);
        chk($sformatf("op%0d_latency", op), 64'(lat), 64'(xlat));
        chk($sformatf("op%0d_rf_wen_pulses", op), 64'(n_rf_wen - rf0), 64'(xrf));
        chk($sformatf("op%0d_pc_wen_pulses", op), 64'(n_pc_wen - pc0), 64'(xpc));
        chk($sformatf("op%0d_step_pulses", op), 64'(n_step - st0), 64'(xst));
    endtask

    initial begin
        int rf0, n;
        for (int i = 0; i < 32; i++) begin
            init_rf[i] = (i == 0) ? 64'd0 : {$urandom, $urandom};
            exp_rf[i]  = init_rf[i];
        end
        init_pc = {$urandom, $urandom} & ~64'd3;
        exp_pc  = init_pc;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        core_init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        // Running core: only STATUS succeeds.
        exec(0, 5'd0, 64'd0);
        exec(4, 5'd5, 64'd0);
        exec(5, 5'd5, 64'd123);
        exec(7, 5'd0, 64'h40);
        exec(3, 5'd0, 64'd0);

        // Halt with ack 3 cycles after halt_req.
        ack_delay = 3;
        exec(1, 5'd0, 64'd0);
        exec(0, 5'd0, 64'd0);

        exec(5, 5'd5, 64'hDEADBEEF);
        exec(4, 5'd5, 64'd0);
        exec(5, 5'd0, 64'd1);
        exec(4, 5'd0, 64'd0);
        exec(6, 5'd0, 64'd0);
        exec(7, 5'd0, 64'h8000_1000);
        exec(6, 5'd0, 64'd0);
        step_delay = 2;
        exec(3, 5'd0, 64'd0);
        exec(6, 5'd0, 64'd0);
        exec(1, 5'd0, 64'd0);

        for (int k = 0; k < 60; k++) begin
            ack_delay  = $urandom_range(1, 5);
            step_delay = $urandom_range(1, 4);
            exec($urandom_range(0, 7), 5'($urandom_range(0, 31)), {$urandom, $urandom});
        end

        exec(2, 5'd0, 64'd0);
        exec(0, 5'd0, 64'd0);
        exec(4, 5'd7, 64'd0);

        // HALT that is never acknowledged.
        never_ack = 1'b1;
        exec(1, 5'd0, 64'd0);
        chk("timeout_halt_req", {63'd0, halt_req}, 64'd0);
        never_ack = 1'b0;

        // ebreak retiring in IDLE.
        ack_delay = 2;
        @(negedge clk);
        is_break = 1'b1;
        @(negedge clk);
        is_break = 1'b0;
`ifdef DBG_BREAK_HALT_EN
        chk("break_halt_req", {63'd0, halt_req}, 64'd1);
        chk("break_no_rsp", {63'd0, rsp_valid}, 64'd0);
        exp_break = 1'b1;
        repeat (ack_delay + 3) @(negedge clk);
        exp_halted = 1'b1;
        exec(0, 5'd0, 64'd0);
        exec(2, 5'd0, 64'd0);
        chk("resume_halt_req", {63'd0, halt_req}, 64'd0);
        exec(0, 5'd0, 64'd0);
`else
        chk("break_ignored", {63'd0, halt_req}, 64'd0);
        repeat (4) @(negedge clk);
        exec(0, 5'd0, 64'd0);
`endif

        // Reset while STEPPING.
        ack_delay = 1;
        exec(1, 5'd0, 64'd0);
        step_delay = 60;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_op    = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stepping_no_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("stepping_halt_req", {63'd0, halt_req}, 64'd1);
        rf0 = n_rf_wen;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_step_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_halted = 1'b0;
        exp_break  = 1'b0;
        repeat (70) @(negedge clk);
        chk("post_reset_no_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("post_reset_no_write", 64'(n_rf_wen - rf0), 64'd0);
        exec(0, 5'd0, 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
